mux_scan: RTL and testbench

MUX_SCAN -- requirements
Module: mux_scan

---
 rtl/mux_pkg.sv | 16 +
 rtl/mux_scan_if.sv | 32 +++
 rtl/mux_nx1.sv | 19 +
 rtl/mux_scan.sv | 125 ++++++++++++
 tb/tb_mux_scan.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared constants, FSM state type and width helper for the mux_scan block.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {StHold, StStep} scan_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_if.sv
// Channel inputs, controls and registered results of mux_scan, grouped as one bundle.
interface mux_scan_if
  import mux_pkg::*;
#(
  parameter int unsigned N_IN = 8,
  parameter int unsigned W    = 4,
  parameter int unsigned DW   = 8
);
  localparam int unsigned SW = (clog2(N_IN) < 1) ? 1 : clog2(N_IN);

  logic [N_IN-1:0][W-1:0] I;
  logic                   en;
  logic                   mode;
  logic [SW-1:0]          s;
  logic [DW-1:0]          dwell;
  logic [W-1:0]           q;
  logic                   q_valid;
  logic [SW-1:0]          sel_cur;
  logic                   wrap;
  logic                   sel_err;

  modport master (
    output I, en, mode, s, dwell,
    input  q, q_valid, sel_cur, wrap, sel_err
  );

  modport slave (
    input  I, en, mode, s, dwell,
    output q, q_valid, sel_cur, wrap, sel_err
  );

endinterface

// File: rtl/mux_nx1.sv
// Combinational N-to-1 channel selector; out-of-range index yields zero.
module mux_nx1
  import mux_pkg::*;
#(
  parameter int unsigned N_IN = 8,
  parameter int unsigned W    = 4,
  localparam int unsigned SW  = (clog2(N_IN) < 1) ? 1 : clog2(N_IN)
) (
  input  logic [N_IN-1:0][W-1:0] data_i,
  input  logic [SW-1:0]          sel_i,
  output logic [W-1:0]           data_o
);

  always_comb begin
    data_o = '0;
    if (32'(sel_i) < N_IN) data_o = data_i[sel_i];
  end

endmodule

// File: rtl/mux_scan.sv
// Registered channel multiplexer with manual select and dwell-timed auto-scan.
module mux_scan
  import mux_pkg::*;
#(
  parameter int unsigned N_IN = 8,
  parameter int unsigned W    = 4,
  parameter int unsigned DW   = 8
) (
  input  logic       clk,
  input  logic       reset,
  mux_scan_if.slave  bus
);

  localparam int unsigned SW = (clog2(N_IN) < 1) ? 1 : clog2(N_IN);

  scan_state_e   state_q, state_d, cur_state;
  logic [SW-1:0] ch_q, ch_d, cur_ch;
  logic [DW-1:0] dc_q, dc_d, cur_dc;
  logic          mode_q, mode_d;
  logic [W-1:0]  q_q, q_d;
  logic [SW-1:0] sel_q, sel_d, mux_sel;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;
  logic [W-1:0]  mux_data;
  logic          entry;

  mux_nx1 #(
    .N_IN (N_IN),
    .W    (W)
  ) u_mux (
    .data_i (bus.I),
    .sel_i  (mux_sel),
    .data_o (mux_data)
  );

  // A scan entry restarts from channel 0 and is evaluated as a HOLD cycle on that same edge.
  always_comb begin
    entry     = (bus.mode == MODE_SCAN) && (mode_q == MODE_MANUAL);
    cur_state = entry ? StHold : state_q;
    cur_ch    = entry ? '0 : ch_q;
    cur_dc    = entry ? '0 : dc_q;
    mux_sel   = (bus.mode == MODE_SCAN) ? cur_ch : bus.s;
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dc_d    = dc_q;
    mode_d  = mode_q;
    q_d     = q_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.en) begin
      q_d     = mux_data;
      sel_d   = mux_sel;
      valid_d = 1'b1;
      mode_d  = bus.mode;
      if (bus.mode == MODE_SCAN) begin
        ch_d = cur_ch;
        unique case (cur_state)
          StHold: begin
            if (cur_dc < bus.dwell) begin
              dc_d    = cur_dc + 1'b1;
              state_d = StHold;
            end else begin
              dc_d    = cur_dc;
              state_d = StStep;
            end
          end
          StStep: begin
            dc_d    = '0;
            state_d = StHold;
            if (32'(cur_ch) == N_IN - 1) begin
              ch_d   = '0;
              wrap_d = 1'b1;
            end else begin
              ch_d = cur_ch + 1'b1;
            end
          end
          default: state_d = StHold;
        endcase
      end else begin
        // Leaving scan drops the position so the next entry starts clean.
        state_d = StHold;
        ch_d    = '0;
        dc_d    = '0;
        err_d   = (32'(bus.s) >= N_IN);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StHold;
      ch_q    <= '0;
      dc_q    <= '0;
      mode_q  <= MODE_MANUAL;
      q_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dc_q    <= dc_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.sel_cur = sel_q;
  assign bus.q_valid = valid_q;
  assign bus.wrap    = wrap_q;
  assign bus.sel_err = err_q;

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan (6 channels) against a position-count reference model.
module tb_mux_scan;

  localparam int NCH = 6;

  typedef struct packed {
    logic [3:0] q;
    logic [2:0] sel;
    logic       v;
    logic       w;
    logic       e;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_t       exp_q[$];
  logic [3:0] ii[NCH];

  // Reference model: a scan run is a count of enabled scan edges since entry.
  logic [3:0] m_q = '0;
  logic [2:0] m_sel = '0;
  bit         m_scan = 1'b0;
  int         m_k = 0;
  int         cur_dw = 0;

  mux_scan_if #(.N_IN(NCH), .W(4), .DW(3)) bus ();

  mux_scan #(.N_IN(NCH), .W(4), .DW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cyc(input bit en, input bit mode, input int s, input int dw);
    exp_t e;
    int   idx;
    @(negedge clk);
    for (int k = 0; k < NCH; k++) bus.I[k] = ii[k];
    bus.en    = en;
    bus.mode  = mode;
    bus.s     = 3'(s);
    bus.dwell = 3'(dw);
    e = '0;
    if (reset) begin
      m_scan = 1'b0;
      m_k    = 0;
    end else if (!en) begin
      e.q   = m_q;
      e.sel = m_sel;
    end else if (!mode) begin
      m_scan = 1'b0;
      if (s < NCH) e.q = ii[s];
      e.sel = 3'(s);
      e.e   = (s >= NCH);
      e.v   = 1'b1;
    end else begin
      if (!m_scan) m_k = 0;
      m_scan = 1'b1;
      idx    = (m_k / (dw + 2)) % NCH;
      e.q    = ii[idx];
      e.sel  = 3'(idx);
      e.v    = 1'b1;
      e.w    = ((m_k % (dw + 2)) == dw + 1) && (idx == NCH - 1);
      m_k++;
    end
    m_q   = e.q;
    m_sel = e.sel;
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " q"}, bus.q, 0);
    chk({tag, " q_valid"}, bus.q_valid, 0);
    chk({tag, " sel_cur"}, bus.sel_cur, 0);
    chk({tag, " wrap"}, bus.wrap, 0);
    chk({tag, " sel_err"}, bus.sel_err, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q", bus.q, e.q);
        chk("sel_cur", bus.sel_cur, e.sel);
        chk("q_valid", bus.q_valid, e.v);
        chk("wrap", bus.wrap, e.w);
        chk("sel_err", bus.sel_err, e.e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit en;
    bit mode;
    int len;
    for (int k = 0; k < NCH; k++) ii[k] = 4'(k + 3);
    bus.en = 1'b0; bus.mode = 1'b0; bus.s = '0; bus.dwell = '0;
    for (int k = 0; k < NCH; k++) bus.I[k] = ii[k];
    #1;
    chk_zero("reset");
    cyc(1, 1, 0, 2);
    cyc(1, 1, 0, 2);
    @(posedge clk);
    #2 reset = 1'b0;

    // Manual select in range and out of range.
    cyc(1, 0, 5, 0);
    cyc(1, 0, 7, 0);
    cyc(1, 0, 2, 0);
    cyc(0, 0, 4, 0);

    // Full scan with dwell=2 through a wrap.
    for (int c = 0; c < 30; c++) cyc(1, 1, 0, 2);

    // Dwell=3 with a frozen stretch mid-hold.
    cyc(1, 0, 0, 3);
    cyc(1, 1, 0, 3);
    cyc(1, 1, 0, 3);
    for (int c = 0; c < 5; c++) cyc(0, 1, 0, 3);
    for (int c = 0; c < 8; c++) cyc(1, 1, 0, 3);

    // Scan to channel 3, dip into manual s=1, re-enter scan.
    cyc(1, 0, 0, 0);
    for (int c = 0; c < 7; c++) cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);

    // Asynchronous reset mid-scan near the last channels.
    cyc(1, 0, 0, 0);
    for (int c = 0; c < 9; c++) cyc(1, 1, 0, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk_zero("async_reset");
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    for (int c = 0; c < 4; c++) cyc(1, 1, 0, 0);

    // Randomized segments; dwell only changes when no scan run is in progress.
    cur_dw = 1;
    for (int seg = 0; seg < 80; seg++) begin
      mode = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 20);
      for (int c = 0; c < len; c++) begin
        for (int k = 0; k < NCH; k++) ii[k] = 4'($urandom_range(0, 15));
        en = ($urandom_range(0, 4) != 0);
        if (!m_scan && ($urandom_range(0, 1) == 1)) cur_dw = $urandom_range(0, 3);
        cyc(en, mode, $urandom_range(0, 7), cur_dw);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    chk("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
